instr_loader: RTL

Boot-time program loader that sits directly upstream of the processor.
- Accepts a framed byte stream over a valid/ready handshake and packs big-endian bytes into 32-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the processor in reset until a complete, checksum-valid image is loaded, then releases it.

---
 rtl/instr_loader_pkg.sv | 23 ++
 rtl/instr_loader_packer.sv | 37 +++
 rtl/instr_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CKSUM_W    = 8;

  // States in which the loader is consuming frame bytes.
  function automatic logic accepting(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CKSUM);
  endfunction

endpackage

// File: rtl/instr_loader_packer.sv
// Packs big-endian bytes into 32-bit words; pulses word_valid the cycle after
// the fourth byte so the word is presented fully assembled.
module instr_loader_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  phase
);

  logic [1:0]  cnt;
  logic [31:0] shreg;

  // Shift in one byte per push; flag completion on the last byte of a word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt        <= 2'd0;
      shreg      <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= push && (cnt == 2'(WORD_BYTES - 1));
      if (push) begin
        shreg <= {shreg[23:0], din};
        cnt   <= cnt + 2'd1;
      end
    end
  end

  assign word  = shreg;
  assign phase = cnt;

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame, writes
// the packed words into instruction memory and releases the CPU from reset
// only once the whole image has been verified.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_LEN_HI | expecting high byte of word count
// S_LEN_LO | expecting low byte of word count; decides length path
// S_DATA   | receiving payload bytes, one write per completed word
// S_CKSUM  | expecting checksum byte
// S_DONE   | image verified, CPU released
// S_ERROR  | overflow or checksum mismatch, CPU held in reset
module instr_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  import instr_loader_pkg::*;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  // Capacity in words; a count equal to capacity is legal and may wrap.
  localparam logic [32:0]       CAP  = 33'd1 << ADDR_W;

  state_t                   state;
  state_t                   nxt;
  logic [7:0]               len_hi;
  logic [8*LEN_BYTES-1:0]   len_n;
  logic [8*LEN_BYTES-1:0]   words_left;
  logic [CKSUM_W-1:0]       cksum;
  logic [ADDR_W-1:0]        addr;
  logic                     xfer;
  logic                     restart;
  logic                     last_byte;
  logic                     pk_push;
  logic [31:0]              pk_word;
  logic                     pk_valid;
  logic [1:0]               pk_phase;

  assign xfer      = in_valid && in_ready;
  assign len_n     = {len_hi, in_data};
  assign last_byte = (pk_phase == 2'(WORD_BYTES - 1));
  assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign pk_push   = (state == S_DATA) && xfer;

  // Next-state decision for the frame parser.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) nxt = S_LEN_HI;
      S_LEN_HI:                if (xfer) nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (33'(len_n) > CAP)  nxt = S_ERROR;
          else if (len_n == '0)  nxt = S_CKSUM;
          else                   nxt = S_DATA;
        end
      end
      S_DATA:  if (xfer && last_byte && (words_left == 16'd1)) nxt = S_CKSUM;
      S_CKSUM: if (xfer) nxt = (in_data == cksum) ? S_DONE : S_ERROR;
      default: nxt = S_IDLE;
    endcase
  end

  // State register, registered status outputs and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len_hi     <= 8'd0;
      words_left <= '0;
      cksum      <= '0;
      addr       <= BASE;
    end else begin
      state    <= nxt;
      in_ready <= accepting(nxt);
      cpu_rst  <= (nxt != S_DONE);
      done     <= (nxt == S_DONE);
      error    <= (nxt == S_ERROR);
      if (restart) begin
        len_hi     <= 8'd0;
        words_left <= '0;
        cksum      <= '0;
        addr       <= BASE;
      end else begin
        if ((state == S_LEN_HI) && xfer) len_hi <= in_data;
        if ((state == S_LEN_LO) && xfer) words_left <= len_n;
        if (pk_push) begin
          cksum <= cksum ^ in_data;
          if (last_byte) words_left <= words_left - 16'd1;
        end
        // Advance after the write so imem_addr holds during the strobe.
        if (pk_valid) addr <= addr + 1'b1;
      end
    end
  end

  instr_loader_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .push       (pk_push),
    .din        (in_data),
    .word       (pk_word),
    .word_valid (pk_valid),
    .phase      (pk_phase)
  );

  assign imem_we    = pk_valid;
  assign imem_wdata = pk_word;
  assign imem_addr  = addr;

endmodule
